data_mem_arbiter: RTL and testbench

DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

---
 rtl/data_mem_arbiter.sv | 205 ++++++++++++++++++++
 tb/tb_data_mem_arbiter.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_arbiter.sv
// Two-port (CPU / DMA) arbiter in front of a single-ported data memory.
// The CPU wins ties, but a DMA request that has been denied MAX_WAIT
// cycles in a row wins the next cycle. A clear_start pulse hands the
// memory to an internal sequencer that writes zero to every word, one
// word per cycle. Requests stay pending until the sequencer finishes.
// Grants and memory strobes are combinational. Read data, rvalid and
// the clear status flags are registered.
module data_mem_arbiter #(
   parameter int MAX_WAIT  = 4,
   parameter int MEM_DEPTH = 256
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cpu_req,
   input  logic        cpu_we,
   input  logic [31:0] cpu_addr,
   input  logic [31:0] cpu_wdata,
   output logic        cpu_gnt,
   output logic        cpu_rvalid,
   output logic [31:0] cpu_rdata,
   input  logic        dma_req,
   input  logic        dma_we,
   input  logic [31:0] dma_addr,
   input  logic [31:0] dma_wdata,
   output logic        dma_gnt,
   output logic        dma_rvalid,
   output logic [31:0] dma_rdata,
   input  logic        clear_start,
   output logic        clear_busy,
   output logic        clear_done,
   output logic        mem_write,
   output logic        mem_read,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata
);

   localparam int CNT_W  = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
   localparam int WAIT_W = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
   localparam logic [CNT_W-1:0]  CLR_LAST = CNT_W'(MEM_DEPTH - 1);
   localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

   typedef enum logic {
      SERVE = 1'b0,
      CLEAR = 1'b1
   } state_e;

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   clr_cnt_q, clr_cnt_d;
   logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
   logic               cpu_rvalid_q, cpu_rvalid_d;
   logic               dma_rvalid_q, dma_rvalid_d;
   logic [31:0]        cpu_rdata_q, cpu_rdata_d;
   logic [31:0]        dma_rdata_q, dma_rdata_d;
   logic               clear_busy_q, clear_busy_d;
   logic               clear_done_q, clear_done_d;
   logic               cpu_win;
   logic               dma_win;

   // Only the low eight address bits select a word; the rest are ignored.
   logic unused_addr_bits;
   assign unused_addr_bits = ^{cpu_addr[31:8], dma_addr[31:8]};

   assign cpu_rvalid = cpu_rvalid_q;
   assign dma_rvalid = dma_rvalid_q;
   assign cpu_rdata  = cpu_rdata_q;
   assign dma_rdata  = dma_rdata_q;
   assign clear_busy = clear_busy_q;
   assign clear_done = clear_done_q;

   // Arbitration, memory drive, clear sequencing and next-state logic.
   always_comb begin
      state_d      = state_q;
      clr_cnt_d    = clr_cnt_q;
      wait_cnt_d   = wait_cnt_q;
      cpu_rvalid_d = 1'b0;
      dma_rvalid_d = 1'b0;
      cpu_rdata_d  = cpu_rdata_q;
      dma_rdata_d  = dma_rdata_q;
      clear_busy_d = clear_busy_q;
      clear_done_d = 1'b0;
      cpu_win      = 1'b0;
      dma_win      = 1'b0;
      cpu_gnt      = 1'b0;
      dma_gnt      = 1'b0;
      mem_write    = 1'b0;
      mem_read     = 1'b0;
      mem_addr     = 32'h0000_0000;
      mem_wdata    = 32'h0000_0000;

      if (!reset) begin
         // While reset is held, grants and memory strobes stay at zero.
         state_d = SERVE;
      end else begin
         case (state_q)
            SERVE: begin
               // A starved DMA overrides the CPU's default priority.
               if (dma_req && ((wait_cnt_q == WAIT_MAX) || !cpu_req)) begin
                  dma_win = 1'b1;
               end else if (cpu_req) begin
                  cpu_win = 1'b1;
               end else begin
                  dma_win = 1'b0;
                  cpu_win = 1'b0;
               end

               if (dma_win) begin
                  dma_gnt   = 1'b1;
                  mem_write = dma_we;
                  mem_read  = ~dma_we;
                  mem_addr  = {24'h00_0000, dma_addr[7:0]};
                  mem_wdata = dma_wdata;
               end else if (cpu_win) begin
                  cpu_gnt   = 1'b1;
                  mem_write = cpu_we;
                  mem_read  = ~cpu_we;
                  mem_addr  = {24'h00_0000, cpu_addr[7:0]};
                  mem_wdata = cpu_wdata;
               end else begin
                  mem_write = 1'b0;
                  mem_read  = 1'b0;
               end

               // A denied DMA cycle counts toward starvation; anything else restarts it.
               if (dma_req && !dma_win) begin
                  wait_cnt_d = wait_cnt_q + WAIT_W'(1);
               end else begin
                  wait_cnt_d = '0;
               end

               cpu_rvalid_d = cpu_win & ~cpu_we;
               dma_rvalid_d = dma_win & ~dma_we;
               if (cpu_win && !cpu_we) begin
                  cpu_rdata_d = mem_rdata;
               end else begin
                  cpu_rdata_d = cpu_rdata_q;
               end
               if (dma_win && !dma_we) begin
                  dma_rdata_d = mem_rdata;
               end else begin
                  dma_rdata_d = dma_rdata_q;
               end

               // The access granted in the start cycle still completes.
               if (clear_start) begin
                  state_d      = CLEAR;
                  clear_busy_d = 1'b1;
               end else begin
                  state_d      = SERVE;
                  clear_busy_d = 1'b0;
               end
            end

            CLEAR: begin
               // The sequencer owns the memory; wait_cnt is left frozen.
               mem_write = 1'b1;
               mem_addr  = 32'(clr_cnt_q);
               mem_wdata = 32'h0000_0000;
               if (clr_cnt_q == CLR_LAST) begin
                  state_d      = SERVE;
                  clr_cnt_d    = '0;
                  clear_busy_d = 1'b0;
                  clear_done_d = 1'b1;
               end else begin
                  state_d      = CLEAR;
                  clr_cnt_d    = clr_cnt_q + CNT_W'(1);
                  clear_busy_d = 1'b1;
               end
            end

            default: begin
               state_d      = SERVE;
               clr_cnt_d    = '0;
               clear_busy_d = 1'b0;
            end
         endcase
      end
   end

   // State and registered outputs; reset aborts any clear in progress.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= SERVE;
         clr_cnt_q    <= '0;
         wait_cnt_q   <= '0;
         cpu_rvalid_q <= 1'b0;
         dma_rvalid_q <= 1'b0;
         cpu_rdata_q  <= 32'h0000_0000;
         dma_rdata_q  <= 32'h0000_0000;
         clear_busy_q <= 1'b0;
         clear_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         clr_cnt_q    <= clr_cnt_d;
         wait_cnt_q   <= wait_cnt_d;
         cpu_rvalid_q <= cpu_rvalid_d;
         dma_rvalid_q <= dma_rvalid_d;
         cpu_rdata_q  <= cpu_rdata_d;
         dma_rdata_q  <= dma_rdata_d;
         clear_busy_q <= clear_busy_d;
         clear_done_q <= clear_done_d;
      end
   end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter: a table of single-cycle vectors
// followed by hand-written clear and reset-during-clear sequences.
module tb_data_mem_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        cpu_req, cpu_we, dma_req, dma_we, clear_start;
   logic [31:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata;
   logic        cpu_gnt, cpu_rvalid, dma_gnt, dma_rvalid;
   logic [31:0] cpu_rdata, dma_rdata;
   logic        clear_busy, clear_done, mem_write, mem_read;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [31:0] mem [0:255];

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   data_mem_arbiter #(.MAX_WAIT(4), .MEM_DEPTH(256)) dut (
      .clk(clk), .reset(reset),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
      .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
      .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
      .clear_start(clear_start), .clear_busy(clear_busy), .clear_done(clear_done),
      .mem_write(mem_write), .mem_read(mem_read), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   // Behavioural data memory: synchronous write, combinational read.
   always @(posedge clk) begin
      if (mem_write) mem[mem_addr[7:0]] <= mem_wdata;
   end
   assign mem_rdata = mem_read ? mem[mem_addr[7:0]] : 32'h0000_0000;

   typedef struct {
      logic c_req, c_we; logic [31:0] c_addr, c_wd;
      logic d_req, d_we; logic [31:0] d_addr, d_wd;
      logic e_cg, e_dg, e_mw, e_mr; logic [31:0] e_ma, e_md;
      logic e_crv; logic [31:0] e_crd;
      logic e_drv; logic [31:0] e_drd;
   } vec_t;

   vec_t vecs [20];

   function automatic vec_t mk(
      input logic cr, cw, input logic [31:0] ca, cd,
      input logic dr, dw, input logic [31:0] da, dd,
      input logic cg, dg, mw, mr, input logic [31:0] ma, md,
      input logic crv, input logic [31:0] crd,
      input logic drv, input logic [31:0] drd);
      vec_t v;
      v.c_req = cr; v.c_we = cw; v.c_addr = ca; v.c_wd = cd;
      v.d_req = dr; v.d_we = dw; v.d_addr = da; v.d_wd = dd;
      v.e_cg = cg; v.e_dg = dg; v.e_mw = mw; v.e_mr = mr; v.e_ma = ma; v.e_md = md;
      v.e_crv = crv; v.e_crd = crd; v.e_drv = drv; v.e_drd = drd;
      return v;
   endfunction

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive_idle();
      cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 32'h0; cpu_wdata = 32'h0;
      dma_req = 1'b0; dma_we = 1'b0; dma_addr = 32'h0; dma_wdata = 32'h0;
      clear_start = 1'b0;
   endtask

   task automatic step(input string name, input vec_t v);
      @(negedge clk);
      cpu_req = v.c_req; cpu_we = v.c_we; cpu_addr = v.c_addr; cpu_wdata = v.c_wd;
      dma_req = v.d_req; dma_we = v.d_we; dma_addr = v.d_addr; dma_wdata = v.d_wd;
      clear_start = 1'b0;
      #1;
      check($sformatf("%s_comb", name),
            {60'h0, cpu_gnt, dma_gnt, mem_write, mem_read, mem_addr, mem_wdata},
            {60'h0, v.e_cg, v.e_dg, v.e_mw, v.e_mr, v.e_ma, v.e_md});
      @(posedge clk); #1;
      check($sformatf("%s_reg", name),
            {62'h0, cpu_rvalid, cpu_rdata, dma_rvalid, dma_rdata},
            {62'h0, v.e_crv, v.e_crd, v.e_drv, v.e_drd});
   endtask

   task automatic check_all_zero(input string name);
      check($sformatf("%s_ports", name),
            {60'h0, cpu_gnt, dma_gnt, clear_busy, clear_done, cpu_rdata, dma_rdata},
            128'h0);
      check($sformatf("%s_mem", name),
            {58'h0, cpu_rvalid, dma_rvalid, mem_write, mem_read, mem_addr, mem_wdata},
            128'h0);
   endtask

   initial begin
      int nz;
      // ---------------- vector table ----------------
      vecs[0] = mk(1'b1,1'b1,32'hFF,32'h12345678, 1'b0,1'b0,32'h0,32'h0,
                   1'b1,1'b0,1'b1,1'b0,32'hFF,32'h12345678, 1'b0,32'h0, 1'b0,32'h0);
      vecs[1] = mk(1'b0,1'b0,32'h0,32'h0, 1'b1,1'b1,32'h10,32'hA5A50001,
                   1'b0,1'b1,1'b1,1'b0,32'h10,32'hA5A50001, 1'b0,32'h0, 1'b0,32'h0);
      vecs[2] = mk(1'b1,1'b1,32'h05,32'hDEADBEEF, 1'b0,1'b0,32'h0,32'h0,
                   1'b1,1'b0,1'b1,1'b0,32'h05,32'hDEADBEEF, 1'b0,32'h0, 1'b0,32'h0);
      vecs[3] = mk(1'b1,1'b0,32'h05,32'h11111111, 1'b0,1'b0,32'h0,32'h0,
                   1'b1,1'b0,1'b0,1'b1,32'h05,32'h11111111, 1'b1,32'hDEADBEEF, 1'b0,32'h0);
      vecs[4] = mk(1'b0,1'b0,32'h0,32'h0, 1'b0,1'b0,32'h0,32'h0,
                   1'b0,1'b0,1'b0,1'b0,32'h0,32'h0, 1'b0,32'hDEADBEEF, 1'b0,32'h0);
      vecs[5] = mk(1'b0,1'b0,32'h0,32'h0, 1'b1,1'b0,32'h1FF,32'h0,
                   1'b0,1'b1,1'b0,1'b1,32'hFF,32'h0, 1'b0,32'hDEADBEEF, 1'b1,32'h12345678);
      vecs[6] = mk(1'b1,1'b0,32'h10,32'h0, 1'b1,1'b1,32'h20,32'hCAFEF00D,
                   1'b1,1'b0,1'b0,1'b1,32'h10,32'h0, 1'b1,32'hA5A50001, 1'b0,32'h12345678);
      vecs[7] = mk(1'b1,1'b1,32'hABCD0030,32'h0BADF00D, 1'b0,1'b0,32'h0,32'h0,
                   1'b1,1'b0,1'b1,1'b0,32'h30,32'h0BADF00D, 1'b0,32'hA5A50001, 1'b0,32'h12345678);
      // Both ports held: four CPU grants, then the starved DMA, twice over.
      for (int i = 0; i < 10; i++) begin
         if (i == 4 || i == 9)
            vecs[8+i] = mk(1'b1,1'b0,32'h05,32'h0, 1'b1,1'b0,32'h10,32'h0,
                           1'b0,1'b1,1'b0,1'b1,32'h10,32'h0, 1'b0,32'hDEADBEEF, 1'b1,32'hA5A50001);
         else
            vecs[8+i] = mk(1'b1,1'b0,32'h05,32'h0, 1'b1,1'b0,32'h10,32'h0,
                           1'b1,1'b0,1'b0,1'b1,32'h05,32'h0, 1'b1,32'hDEADBEEF,
                           1'b0, (i < 4) ? 32'h12345678 : 32'hA5A50001);
      end
      vecs[18] = mk(1'b0,1'b0,32'h0,32'h0, 1'b1,1'b1,32'h05,32'h55AA55AA,
                    1'b0,1'b1,1'b1,1'b0,32'h05,32'h55AA55AA, 1'b0,32'hDEADBEEF, 1'b0,32'hA5A50001);
      vecs[19] = mk(1'b1,1'b0,32'h05,32'h0, 1'b0,1'b0,32'h0,32'h0,
                    1'b1,1'b0,1'b0,1'b1,32'h05,32'h0, 1'b1,32'h55AA55AA, 1'b0,32'hA5A50001);

      // ---------------- reset state ----------------
      drive_idle();
      reset = 1'b0;
      cpu_req = 1'b1; dma_req = 1'b1; cpu_addr = 32'h44; dma_we = 1'b1;
      #12;
      check_all_zero("reset_init");
      @(negedge clk);
      drive_idle();
      #2 reset = 1'b1;

      // ---------------- table ----------------
      for (int i = 0; i < 20; i++) step($sformatf("vec%0d", i), vecs[i]);

      // ---------------- clear with both ports requesting ----------------
      @(negedge clk);
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h05;
      dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h10;
      clear_start = 1'b1;
      #1;
      check("clr_start_gnt", {124'h0, cpu_gnt, dma_gnt, clear_busy, mem_read},
            {124'h0, 1'b1, 1'b0, 1'b0, 1'b1});
      @(posedge clk); #1;
      check("clr_start_rd", {94'h0, cpu_rvalid, cpu_rdata, clear_busy},
            {94'h0, 1'b1, 32'h55AA55AA, 1'b1});
      for (int k = 0; k < 256; k++) begin
         @(negedge clk);
         clear_start = (k == 50) ? 1'b1 : 1'b0;
         #1;
         check($sformatf("clr_cycle%0d", k),
               {58'h0, mem_write, mem_read, mem_addr, mem_wdata, cpu_gnt, dma_gnt, clear_busy, clear_done},
               {58'h0, 1'b1, 1'b0, 32'(k), 32'h0, 1'b0, 1'b0, 1'b1, 1'b0});
      end
      // wait_cnt was 1 when the clear began and is frozen, so three CPU
      // grants precede the DMA grant.
      for (int c = 0; c < 4; c++) begin
         @(negedge clk); #1;
         check($sformatf("post_clr%0d", c),
               {90'h0, clear_done, clear_busy, cpu_gnt, dma_gnt, mem_addr, cpu_rvalid, cpu_rdata},
               {90'h0, (c == 0), 1'b0, (c != 3), (c == 3),
                (c == 3) ? 32'h10 : 32'h05, (c != 0), (c == 0) ? 32'h55AA55AA : 32'h0});
      end
      nz = 0;
      for (int i = 0; i < 256; i++) if (mem[i] !== 32'h0) nz++;
      check("mem_zeroed", 128'(nz), 128'(0));

      // ---------------- reset during clear ----------------
      step("pre_rst0", mk(1'b1,1'b1,32'h07,32'h77, 1'b0,1'b0,32'h0,32'h0,
           1'b1,1'b0,1'b1,1'b0,32'h07,32'h77, 1'b0,32'h0, 1'b0,32'h0));
      step("pre_rst1", mk(1'b0,1'b0,32'h0,32'h0, 1'b1,1'b1,32'h08,32'h88,
           1'b0,1'b1,1'b1,1'b0,32'h08,32'h88, 1'b0,32'h0, 1'b0,32'h0));
      step("pre_rst2", mk(1'b1,1'b0,32'h07,32'h0, 1'b0,1'b0,32'h0,32'h0,
           1'b1,1'b0,1'b0,1'b1,32'h07,32'h0, 1'b1,32'h77, 1'b0,32'h0));
      step("pre_rst3", mk(1'b0,1'b0,32'h0,32'h0, 1'b1,1'b0,32'h08,32'h0,
           1'b0,1'b1,1'b0,1'b1,32'h08,32'h0, 1'b0,32'h77, 1'b1,32'h88));
      @(negedge clk);
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h07;
      dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h08;
      clear_start = 1'b1;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         clear_start = 1'b0;
      end
      @(negedge clk); #1;
      check("clr_at100", {94'h0, clear_busy, mem_addr, mem_write}, {94'h0, 1'b1, 32'd100, 1'b1});
      reset = 1'b0;
      #1;
      check_all_zero("reset_mid_clear");
      @(negedge clk);
      @(negedge clk);
      #2 reset = 1'b1;
      @(negedge clk); #1;
      check("after_reset", {92'h0, clear_busy, clear_done, cpu_gnt, dma_gnt, mem_addr},
            {92'h0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h07});
      drive_idle();
      @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
